// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad responder: sequencing states, LFSR taps
// and the key-code to matrix position map (also used by the scanner bench).
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS_B = 3'd1,
    HOLD    = 3'd2,
    REL_B   = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Row of a key on the 4x4 matrix (top row 1 2 3 A, bottom row E 0 F D).
  function automatic logic [1:0] key_to_row(input logic [3:0] key);
    logic [1:0] row;
    case (key)
      4'h1, 4'h2, 4'h3, 4'hA: row = 2'd0;
      4'h4, 4'h5, 4'h6, 4'hB: row = 2'd1;
      4'h7, 4'h8, 4'h9, 4'hC: row = 2'd2;
      default:                row = 2'd3;
    endcase
    return row;
  endfunction

  // Column of a key on the 4x4 matrix.
  function automatic logic [1:0] key_to_col(input logic [3:0] key);
    logic [1:0] col;
    case (key)
      4'h1, 4'h4, 4'h7, 4'hE: col = 2'd0;
      4'h2, 4'h5, 4'h8, 4'h0: col = 2'd1;
      4'h3, 4'h6, 4'h9, 4'hF: col = 2'd2;
      default:                col = 2'd3;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/keypad_responder_lfsr16.sv
// 16-bit right-shifting Galois LFSR, free-running; a zero seed would lock up,
// so it is replaced by 1.
module lfsr16
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Load the seed on reset, otherwise advance one step per clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/keypad_responder.sv
// Keypad matrix responder: on request closes one key contact, with
// pseudo-random chatter on press and release, and answers the scanner's
// column drive on the matching row line.
//
// state   | meaning
// IDLE    | contact open, ready for a press request
// PRESS_B | press chatter, contact follows LFSR bit 0
// HOLD    | contact solidly closed for cmd_hold * HOLD_UNIT cycles
// REL_B   | release chatter, contact follows LFSR bit 0
// DONE    | contact open, done pulse, back to IDLE
module keypad_responder
  import keypad_pkg::*;
#(
  parameter int          BOUNCE_CYCLES = 2000,
  parameter int          HOLD_UNIT     = 12000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  keypad_cols,
  output logic [3:0]  keypad_rows,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_key,
  input  logic [15:0] cmd_hold,
  output logic        busy,
  output logic        done
);

  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam int BW = HAS_BOUNCE ? $clog2(BOUNCE_CYCLES + 1) : 1;
  localparam int UW = (HOLD_UNIT > 1) ? $clog2(HOLD_UNIT) : 1;
  localparam logic [BW-1:0] B_LOAD = BW'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [UW-1:0] U_LOAD = UW'(HOLD_UNIT - 1);

  state_e        state_q, state_d;
  state_e        after_press, after_hold;
  logic [3:0]    key_q;
  logic [15:0]   hold_q, hold_src;
  logic          contact_q;
  logic [BW-1:0] bcnt_q;
  logic [UW-1:0] ucnt_q;
  logic [15:0]   hcnt_q;
  logic [15:0]   lfsr_q;
  logic          lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Only bit 0 drives the chatter; the upper bits are pure LFSR state.
  assign lfsr_unused = ^lfsr_q[15:1];

  // On the accept edge the hold count is still on the command bus.
  assign hold_src    = (state_q == IDLE) ? cmd_hold : hold_q;
  assign after_hold  = HAS_BOUNCE ? REL_B : DONE;
  assign after_press = (hold_src != 16'd0) ? HOLD : after_hold;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  // Next-state selection; phases of zero length are skipped entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = HAS_BOUNCE ? PRESS_B : after_press;
      PRESS_B: if (bcnt_q == '0) state_d = after_press;
      HOLD:    if (ucnt_q == '0 && hcnt_q == 16'd0) state_d = after_hold;
      REL_B:   if (bcnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched command, contact and phase down-counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      key_q     <= 4'h0;
      hold_q    <= 16'd0;
      contact_q <= 1'b0;
      bcnt_q    <= '0;
      ucnt_q    <= '0;
      hcnt_q    <= 16'd0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && cmd_valid) begin
        key_q  <= cmd_key;
        hold_q <= cmd_hold;
      end

      case (state_d)
        HOLD:           contact_q <= 1'b1;
        PRESS_B, REL_B: contact_q <= lfsr_q[0];
        default:        contact_q <= 1'b0;
      endcase

      if (state_d != state_q && (state_d == PRESS_B || state_d == REL_B)) begin
        bcnt_q <= B_LOAD;
      end else if (bcnt_q != '0) begin
        bcnt_q <= bcnt_q - BW'(1);
      end

      if (state_d == HOLD && state_q != HOLD) begin
        ucnt_q <= U_LOAD;
        hcnt_q <= hold_src - 16'd1;
      end else if (state_q == HOLD) begin
        if (ucnt_q == '0) begin
          ucnt_q <= U_LOAD;
          if (hcnt_q != 16'd0) hcnt_q <= hcnt_q - 16'd1;
        end else begin
          ucnt_q <= ucnt_q - UW'(1);
        end
      end
    end
  end

  // Row sense: the closed key pulls its row low only while its column is driven.
  always_comb begin
    keypad_rows = 4'b1111;
    if (contact_q && !keypad_cols[key_to_col(key_q)]) begin
      keypad_rows[key_to_row(key_q)] = 1'b0;
    end
  end

endmodule
